// File: rtl/enemy_march_ctrl_if.sv
// Step-request bundle between the march controller and the formation mover.
// master = controller side, slave = mover side.
interface enemy_march_ctrl_if;
  logic [10:0] posxE1;
  logic [5:0]  alive;
  logic        pause;
  logic        mueva;
  logic        dir;
  logic        bajar;
  logic        wave_clear;

  modport master (
    input  posxE1, alive, pause,
    output mueva, dir, bajar, wave_clear
  );

  modport slave (
    output posxE1, alive, pause,
    input  mueva, dir, bajar, wave_clear
  );
endinterface

// File: rtl/enemy_march_ctrl.sv
// Enemy formation march pacing: period shrinks as enemies die,
// issues step / step-down requests and flags a cleared wave.
module enemy_march_ctrl #(
  parameter int BASE_PERIOD = 12_500_000,
  parameter int PERIOD_STEP = 200_000,
  parameter int MIN_PERIOD  = 500_000,
  parameter int MAX_ENEMIES = 55,
  parameter int LEFT_LIMIT  = 8,
  parameter int RIGHT_LIMIT = 632,
  parameter int FORMATION_W = 176
) (
  input  logic                  clk,
  input  logic                  reset,
  enemy_march_ctrl_if.master    bus
);

  localparam int PMAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD
                                                   : MIN_PERIOD;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int CW   = (PW > 24) ? PW : 24;

  localparam logic [39:0] BASE40 = 40'(BASE_PERIOD);
  localparam logic [39:0] STEP40 = 40'(PERIOD_STEP);
  localparam logic [39:0] MIN40  = 40'(MIN_PERIOD);
  localparam logic [39:0] MAXE40 = 40'(MAX_ENEMIES);

  localparam logic [11:0] RLIM12 = 12'(RIGHT_LIMIT);
  localparam logic [11:0] FW12   = 12'(FORMATION_W);
  localparam logic [10:0] LLIM11 = 11'(LEFT_LIMIT);

  typedef enum logic [1:0] {
    MARCH_R,
    MARCH_L,
    CLEAR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] p;

  logic [39:0]   eff;
  logic [39:0]   red;
  logic [39:0]   p_calc;
  logic [CW-1:0] p_new;
  logic          at_end;
  logic          at_right;
  logic          at_left;
  logic          dead;

  // period from the current (clamped) alive count, floored at MIN_PERIOD
  always_comb begin
    eff = (40'(bus.alive) > MAXE40) ? MAXE40 : 40'(bus.alive);
    red = (MAXE40 - eff) * STEP40;
    if (red + MIN40 >= BASE40)
      p_calc = MIN40;
    else
      p_calc = BASE40 - red;
    p_new = CW'(p_calc);
  end

  // tick and screen-edge decode; edge sum widened to 12 bits
  always_comb begin
    at_end   = (cnt == p - CW'(1));
    at_right = ({1'b0, bus.posxE1} + FW12) >= RLIM12;
    at_left  = bus.posxE1 <= LLIM11;
    dead     = (bus.alive == 6'd0);
  end

  // march FSM with period counter and registered step outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= MARCH_R;
      cnt            <= '0;
      p              <= p_new;
      bus.mueva      <= 1'b0;
      bus.bajar      <= 1'b0;
      bus.wave_clear <= 1'b0;
      bus.dir        <= 1'b0;
    end else begin
      bus.mueva      <= 1'b0;
      bus.bajar      <= 1'b0;
      bus.wave_clear <= 1'b0;
      unique case (state)
        MARCH_R, MARCH_L: begin
          if (dead) begin
            state          <= CLEAR;
            cnt            <= '0;
            bus.wave_clear <= 1'b1;
          end else if (!bus.pause) begin
            if (at_end) begin
              cnt <= '0;
              p   <= p_new;
              if (state == MARCH_R && at_right) begin
                state     <= MARCH_L;
                bus.dir   <= 1'b1;
                bus.bajar <= 1'b1;
              end else if (state == MARCH_L && at_left) begin
                state     <= MARCH_R;
                bus.dir   <= 1'b0;
                bus.bajar <= 1'b1;
              end else begin
                bus.mueva <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        CLEAR: begin
          if (!dead) begin
            state   <= MARCH_R;
            cnt     <= '0;
            p       <= p_new;
            bus.dir <= 1'b0;
          end
        end
        default: begin
          state <= MARCH_R;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Bench for enemy_march_ctrl: directed vector table plus
// randomized run against a behavioural period/direction model.
module tb_enemy_march_ctrl;

  localparam int BP = 10;
  localparam int PS = 2;
  localparam int MP = 4;
  localparam int ME = 4;
  localparam int LL = 8;
  localparam int RL = 100;
  localparam int FW = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enemy_march_ctrl_if bus ();

  enemy_march_ctrl #(
    .BASE_PERIOD(BP),
    .PERIOD_STEP(PS),
    .MIN_PERIOD (MP),
    .MAX_ENEMIES(ME),
    .LEFT_LIMIT (LL),
    .RIGHT_LIMIT(RL),
    .FORMATION_W(FW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit rst;
    int alive;
    int posx;
    bit pause;
    int n;
    bit mv;
    bit bj;
    bit wc;
    bit dir;
  } vec_t;

  vec_t tbl[$];
  int checks   = 0;
  int failures = 0;

  // model state
  int m_mode;
  int m_cnt;
  int m_p;
  bit e_mv, e_bj, e_wc, e_dir;

  function automatic vec_t v(bit r, int a, int px, bit pz, int n,
                             bit mv, bit bj, bit wc, bit d);
    vec_t t;
    t.rst = r; t.alive = a; t.posx = px; t.pause = pz; t.n = n;
    t.mv = mv; t.bj = bj; t.wc = wc; t.dir = d;
    return t;
  endfunction

  function automatic int period(int a);
    int e;
    int q;
    e = (a > ME) ? ME : a;
    q = BP - (ME - e) * PS;
    return (q < MP) ? MP : q;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit r, int a, int px, bit pz);
    reset      = r;
    bus.alive  = 6'(a);
    bus.posxE1 = 11'(px);
    bus.pause  = pz;
  endtask

  // mode: 0 marching right, 1 marching left, 2 wave cleared
  task automatic model(bit r, int a, int px, bit pz);
    e_mv = 0; e_bj = 0; e_wc = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_p = period(a); e_dir = 0;
    end else if (m_mode == 2) begin
      if (a != 0) begin
        m_mode = 0; m_cnt = 0; m_p = period(a); e_dir = 0;
      end
    end else if (a == 0) begin
      m_mode = 2; m_cnt = 0; e_wc = 1;
    end else if (!pz) begin
      if (m_cnt + 1 == m_p) begin
        bit hit;
        m_cnt = 0;
        m_p   = period(a);
        hit = (m_mode == 0) ? (px + FW >= RL) : (px <= LL);
        if (hit) begin
          e_bj   = 1;
          m_mode = 1 - m_mode;
          e_dir  = (m_mode == 1);
        end else begin
          e_mv = 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    drive(1, 4, 50, 0);

    // reset and steady march, P=10
    tbl.push_back(v(1, 4, 50, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 4, 50, 0, 10, 1, 0, 0, 0));
    tbl.push_back(v(0, 4, 50, 0, 10, 1, 0, 0, 0));
    tbl.push_back(v(0, 4, 50, 0, 10, 1, 0, 0, 0));
    // alive=1: current period stays 10, then clamped to 4
    tbl.push_back(v(0, 1, 50, 0, 10, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 50, 0, 4, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 50, 0, 4, 1, 0, 0, 0));
    // wave cleared, quiet, then restart with P=8
    tbl.push_back(v(0, 0, 50, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 50, 0, 6, 0, 0, 0, 0));
    tbl.push_back(v(0, 3, 50, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 3, 50, 0, 8, 1, 0, 0, 0));
    // right edge, then plain step leftward
    tbl.push_back(v(0, 3, 80, 0, 8, 0, 1, 0, 1));
    tbl.push_back(v(0, 3, 60, 0, 8, 1, 0, 0, 1));
    // left edge at exactly LEFT_LIMIT
    tbl.push_back(v(0, 3, 8, 0, 8, 0, 1, 0, 0));
    tbl.push_back(v(0, 3, 90, 0, 8, 0, 1, 0, 1));
    tbl.push_back(v(0, 3, 9, 0, 8, 1, 0, 0, 1));
    tbl.push_back(v(0, 3, 8, 0, 8, 0, 1, 0, 0));
    // one below right edge, then max posx (no overflow)
    tbl.push_back(v(0, 3, 79, 0, 8, 1, 0, 0, 0));
    tbl.push_back(v(0, 3, 2047, 0, 8, 0, 1, 0, 1));
    // back to P=10, pause at counter 9
    tbl.push_back(v(0, 4, 50, 0, 8, 1, 0, 0, 1));
    tbl.push_back(v(0, 4, 50, 0, 9, 0, 0, 0, 1));
    tbl.push_back(v(0, 4, 50, 1, 5, 0, 0, 0, 1));
    tbl.push_back(v(0, 4, 50, 0, 1, 1, 0, 0, 1));
    // reset mid-period while marching left
    tbl.push_back(v(0, 4, 50, 0, 4, 0, 0, 0, 1));
    tbl.push_back(v(1, 4, 50, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 4, 50, 0, 10, 1, 0, 0, 0));
    // alive above MAX_ENEMIES clamps to full formation
    tbl.push_back(v(0, 63, 50, 0, 10, 1, 0, 0, 0));
    tbl.push_back(v(0, 63, 50, 0, 10, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].alive, tbl[i].posx, tbl[i].pause);
      for (int k = 1; k <= tbl[i].n; k++) begin
        @(posedge clk);
        #1;
        if (k < tbl[i].n) begin
          chk($sformatf("v%0d_quiet_mueva", i), int'(bus.mueva), 0);
          chk($sformatf("v%0d_quiet_bajar", i), int'(bus.bajar), 0);
          chk($sformatf("v%0d_quiet_wclr", i),
              int'(bus.wave_clear), 0);
        end else begin
          chk($sformatf("v%0d_mueva", i), int'(bus.mueva),
              int'(tbl[i].mv));
          chk($sformatf("v%0d_bajar", i), int'(bus.bajar),
              int'(tbl[i].bj));
          chk($sformatf("v%0d_wclr", i), int'(bus.wave_clear),
              int'(tbl[i].wc));
          chk($sformatf("v%0d_dir", i), int'(bus.dir),
              int'(tbl[i].dir));
        end
      end
    end

    // randomized run against the model
    begin
      int a  = 4;
      int px = 50;
      bit pz = 0;
      bit r;
      for (int c = 0; c < 4000; c++) begin
        r = (c == 0) || ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 19) == 0)
          a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
        if ($urandom_range(0, 4) == 0)
          px = ($urandom_range(0, 15) == 0) ? 2047
                                            : $urandom_range(0, 120);
        if ($urandom_range(0, 14) == 0)
          pz = ~pz;
        drive(r, a, px, pz);
        model(r, a, px, pz);
        @(posedge clk);
        #1;
        chk($sformatf("rnd%0d_mueva", c), int'(bus.mueva), int'(e_mv));
        chk($sformatf("rnd%0d_bajar", c), int'(bus.bajar), int'(e_bj));
        chk($sformatf("rnd%0d_wclr", c), int'(bus.wave_clear),
            int'(e_wc));
        chk($sformatf("rnd%0d_dir", c), int'(bus.dir), int'(e_dir));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_march_ctrl.md
ENEMY_MARCH_CTRL -- requirements
Module: enemy_march_ctrl

Interface
REQ-001 Parameter BASE_PERIOD, 12_500_000, clock cycles between march ticks with a full formation.
REQ-002 Parameter PERIOD_STEP, 200_000, period reduction per destroyed enemy.
REQ-003 Parameter MIN_PERIOD, 500_000, lower bound on the tick period; always >= 2.
REQ-004 Parameter MAX_ENEMIES, 55, formation size at wave start.
REQ-005 Parameter LEFT_LIMIT, 8, leftmost allowed formation X in pixels.
REQ-006 Parameter RIGHT_LIMIT, 632, rightmost allowed formation right-edge X in pixels.
REQ-007 Parameter FORMATION_W, 176, formation width in pixels.
REQ-008 Port clk, input, 1, sole clock; all logic is synchronous to its rising edge.
REQ-009 Port reset, input, 1, synchronous active-high reset.
REQ-010 Port posxE1, input, 11, current formation left-edge X from the mover stage.
REQ-011 Port alive, input, 6, count of live enemies.
REQ-012 Port pause, input, 1, freezes the march while high.
REQ-013 Port mueva, output, 1, one-cycle step request to the mover stage.
REQ-014 Port dir, output, 1, march direction to the mover stage: 0 = right, 1 = left.
REQ-015 Port bajar, output, 1, one-cycle step-down request at a screen edge.
REQ-016 Port wave_clear, output, 1, one-cycle pulse when alive first reaches 0.

Function
REQ-017 The FSM SHALL have exactly three states: MARCH_R (dir=0), MARCH_L (dir=1) and CLEAR.
REQ-018 The effective alive count SHALL be min(alive, MAX_ENEMIES).
REQ-019 The period P SHALL be max(MIN_PERIOD, BASE_PERIOD - (MAX_ENEMIES - effective alive) * PERIOD_STEP), computed in at least 32 bits with no negative wrap.
REQ-020 P SHALL be latched when the period counter wraps to 0, so an alive change mid-period takes effect from the next period.
REQ-021 The period counter (24 bits minimum) SHALL count 0..P-1 while in a MARCH state with pause low, and SHALL hold its value while pause is high.
REQ-022 A tick SHALL occur on the cycle where counter == P-1 and pause is low; on that edge the counter returns to 0.
REQ-023 On a tick in MARCH_R with posxE1 + FORMATION_W >= RIGHT_LIMIT, the block SHALL assert bajar (not mueva) in the next cycle and move to MARCH_L.
REQ-024 On a tick in MARCH_L with posxE1 <= LEFT_LIMIT, the block SHALL assert bajar (not mueva) in the next cycle and move to MARCH_R.
REQ-025 On any other tick, the block SHALL assert mueva in the next cycle and keep its state.
REQ-026 mueva and bajar SHALL never both be high, and each SHALL be high for exactly one cycle per tick.
REQ-027 posxE1 SHALL be sampled only on tick cycles; the edge comparison SHALL use 12-bit arithmetic so no overflow occurs.
REQ-028 When alive == 0 in any MARCH state, the block SHALL enter CLEAR, pulse wave_clear for one cycle and suppress tick outputs; alive == 0 takes priority over a simultaneous tick.
REQ-029 In CLEAR, when alive becomes nonzero, the block SHALL enter MARCH_R with the counter at 0 and P recomputed.
REQ-030 dir SHALL be a registered decode of the state; in CLEAR, dir SHALL hold its last value.

Reset
REQ-031 reset SHALL force, on the next rising edge: state MARCH_R, counter 0, P computed from current alive, and mueva = bajar = wave_clear = dir = 0.
REQ-032 reset asserted mid-period or in CLEAR SHALL discard any pending tick and restart the period from 0 after release.
REQ-033 reset SHALL take priority over pause, alive and tick.

Verification
Scenarios use BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=4, MAX_ENEMIES=4, LEFT_LIMIT=8, RIGHT_LIMIT=100, FORMATION_W=20.
REQ-034 Release reset with alive=4, posxE1=50, pause=0 -> mueva pulses in cycles 10, 20 and 30 after release, dir=0, bajar=0.
REQ-035 Set alive=1 -> next period P=4 (clamped from 10-6), so mueva pulses every 4 cycles; then alive=0 -> wave_clear pulses once and no further mueva/bajar occur; then alive=3 -> first mueva 8 cycles later.
REQ-036 posxE1=80 at a tick in MARCH_R -> bajar for 1 cycle, no mueva, dir=1 from the next cycle; with posxE1=60 at the following tick -> mueva only.
REQ-037 dir=1, posxE1=8 at a tick -> bajar, dir returns to 0; posxE1=9 at a tick -> mueva.
REQ-038 Raise pause when counter=9 and hold it 5 cycles -> no pulse while paused; mueva fires 1 cycle after pause falls.
REQ-039 Assert reset for 1 cycle mid-period while dir=1 -> all outputs 0, dir=0, and the next mueva occurs 10 cycles after release.
